envelope_shaper: RTL and testbench

Parametrised amplitude-envelope stage between the note sample generator and the codec output path. Applies a stepped gain of level/STEPS to every signed sample. The level follows an attack, decay and release envelope. The envelope is timed in `new_frame` pulses and scaled by the note duration. Decay spacing is linear or exponential (each interval doubles), and the envelope can be released early.

---
 rtl/envelope_shaper.sv | 154 +++++++++++++++
 tb/tb_envelope_shaper.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/envelope_shaper.sv
// rtl/envelope_shaper.sv - attack/decay/release gain envelope applied to a signed sample stream
// Gain is level/STEPS; envelope time base is new_frame, decay spacing linear or doubling.
module envelope_shaper #(
    parameter int SAMPLE_W = 16,
    parameter int STEPS    = 8,
    parameter int DUR_W    = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       new_frame,
    input  logic                       note_start,
    input  logic                       note_release,
    input  logic [DUR_W-1:0]           note_duration,
    input  logic                       decay_mode,
    input  logic                       attack_en,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_out_valid,
    output logic [$clog2(STEPS):0]     level,
    output logic                       busy,
    output logic                       env_done
);

    localparam int SH     = $clog2(STEPS);
    localparam int LVL_W  = SH + 1;
    localparam int CNT_W  = DUR_W + STEPS;
    localparam int K_W    = SH + 1;
    localparam int PROD_W = SAMPLE_W + 1 + LVL_W;
    localparam logic [LVL_W-1:0] FULL = LVL_W'(STEPS);

    typedef enum logic [1:0] {IDLE, ATTACK, DECAY, RELEASE} state_t;

    state_t            state, state_n;
    logic [LVL_W-1:0]  level_n;
    logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc, d_ext, intv;
    logic [K_W-1:0]    k, k_n;
    logic [DUR_W-1:0]  dur, dur_n;
    logic              mode, mode_n;
    logic              done_n;

    always_comb begin
        state_n = state;
        level_n = level;
        cnt_n   = cnt;
        k_n     = k;
        dur_n   = dur;
        mode_n  = mode;
        done_n  = 1'b0;
        d_ext   = CNT_W'(dur);
        intv    = mode ? (d_ext << k) : d_ext;
        cnt_inc = cnt + 1'b1;

        if (note_start) begin
            // start beats release and swallows a coincident new_frame
            dur_n  = (note_duration == '0) ? DUR_W'(1) : note_duration;
            mode_n = decay_mode;
            cnt_n  = '0;
            k_n    = '0;
            if (attack_en) begin
                state_n = ATTACK;
                level_n = '0;
            end else begin
                state_n = DECAY;
                level_n = FULL;
            end
        end else if (note_release && (state == ATTACK || state == DECAY)) begin
            state_n = RELEASE;
        end else if (new_frame) begin
            case (state)
                ATTACK: begin
                    level_n = level + 1'b1;
                    if (level_n == FULL) begin
                        state_n = DECAY;
                        cnt_n   = '0;
                        k_n     = '0;
                    end
                end
                DECAY: begin
                    if (cnt_inc == intv) begin
                        level_n = level - 1'b1;
                        cnt_n   = '0;
                        k_n     = k + 1'b1;
                        if (level_n == '0) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                RELEASE: begin
                    // release entered from ATTACK may already sit at level 0
                    if (level <= LVL_W'(1)) begin
                        level_n = '0;
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        level_n = level - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            level    <= '0;
            cnt      <= '0;
            k        <= '0;
            dur      <= DUR_W'(1);
            mode     <= 1'b0;
            env_done <= 1'b0;
        end else begin
            state    <= state_n;
            level    <= level_n;
            cnt      <= cnt_n;
            k        <= k_n;
            dur      <= dur_n;
            mode     <= mode_n;
            env_done <= done_n;
        end
    end

    assign busy = (state != IDLE);

    // magnitude in SAMPLE_W+1 bits so the most negative sample negates cleanly
    logic              neg;
    logic [SAMPLE_W:0] ext, mag, mag_scaled;
    logic [PROD_W-1:0] prod;

    always_comb begin
        neg        = sample_in[SAMPLE_W-1];
        ext        = {sample_in[SAMPLE_W-1], sample_in};
        mag        = neg ? (~ext + 1'b1) : ext;
        prod       = PROD_W'(mag) * PROD_W'(level);
        mag_scaled = (SAMPLE_W+1)'(prod >> SH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
        end else begin
            sample_out_valid <= sample_valid;
            if (sample_valid) begin
                sample_out <= SAMPLE_W'(neg ? (~mag_scaled + 1'b1) : mag_scaled);
            end
        end
    end

endmodule

// File: tb/tb_envelope_shaper.sv
// tb/tb_envelope_shaper.sv - directed table and sequence checks for envelope_shaper
module tb_envelope_shaper;

    logic               clk;
    logic               reset;
    logic               new_frame;
    logic               note_start;
    logic               note_release;
    logic [5:0]         note_duration;
    logic               decay_mode;
    logic               attack_en;
    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic signed [15:0] sample_out;
    logic               sample_out_valid;
    logic [3:0]         level;
    logic               busy;
    logic               env_done;

    envelope_shaper #(.SAMPLE_W(16), .STEPS(8), .DUR_W(6)) dut (
        .clk(clk), .reset(reset), .new_frame(new_frame), .note_start(note_start),
        .note_release(note_release), .note_duration(note_duration),
        .decay_mode(decay_mode), .attack_en(attack_en), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_out(sample_out),
        .sample_out_valid(sample_out_valid), .level(level), .busy(busy),
        .env_done(env_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always @(posedge clk) if (env_done === 1'b1) done_cnt++;

    typedef struct {
        int frames;
        int sin;
        int exp_level;
        int exp_out;
        int exp_busy;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            new_frame = 1'b1;
            @(negedge clk);
            new_frame = 1'b0;
        end
    endtask

    task automatic do_sample(input int s);
        sample_in    = s[15:0];
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic start(input int dur, input logic mode, input logic att);
        note_duration = dur[5:0];
        decay_mode    = mode;
        attack_en     = att;
        note_start    = 1'b1;
        @(negedge clk);
        note_start    = 1'b0;
    endtask

    int cum[8];
    int prev;
    int d0;

    initial begin
        #200000;
        $display("FAIL timeout actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{0,  10400, 8,  10400, 1};
        tbl[1]  = '{2,  10400, 8,  10400, 1};
        tbl[2]  = '{1,  10400, 7,   9100, 1};
        tbl[3]  = '{0, -10400, 7,  -9100, 1};
        tbl[4]  = '{0,     -1, 7,      0, 1};
        tbl[5]  = '{3,  10400, 6,   7800, 1};
        tbl[6]  = '{3,  10400, 5,   6500, 1};
        tbl[7]  = '{3, -10400, 4,  -5200, 1};
        tbl[8]  = '{3,  10400, 3,   3900, 1};
        tbl[9]  = '{3,  10400, 2,   2600, 1};
        tbl[10] = '{3,  10400, 1,   1300, 1};
        tbl[11] = '{2,  10400, 1,   1300, 1};
        tbl[12] = '{1,  10400, 0,      0, 0};
        cum = '{3, 9, 21, 45, 93, 189, 381, 765};

        reset = 1'b0; new_frame = 0; note_start = 0; note_release = 0;
        note_duration = 0; decay_mode = 0; attack_en = 0; sample_in = 0; sample_valid = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_level", int'(level), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out", int'(sample_out), 0);
        chk("rst_valid", int'(sample_out_valid), 0);
        chk("rst_done", int'(env_done), 0);
        reset = 1'b1;
        @(negedge clk);

        // linear decay
        d0 = done_cnt;
        start(3, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            frames(tbl[i].frames);
            do_sample(tbl[i].sin);
            chk($sformatf("lin_level[%0d]", i), int'(level), tbl[i].exp_level);
            chk($sformatf("lin_out[%0d]", i), int'(sample_out), tbl[i].exp_out);
            chk($sformatf("lin_busy[%0d]", i), int'(busy), tbl[i].exp_busy);
        end
        chk("lin_valid", int'(sample_out_valid), 1);
        @(negedge clk);
        chk("hold_valid", int'(sample_out_valid), 0);
        chk("hold_out", int'(sample_out), 0);
        chk("lin_done_cnt", done_cnt - d0, 1);
        frames(3);
        chk("idle_level", int'(level), 0);
        chk("idle_done_cnt", done_cnt - d0, 1);

        // exponential decay
        d0 = done_cnt;
        start(3, 1'b1, 1'b0);
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            frames(cum[i] - 1 - prev);
            chk($sformatf("exp_pre[%0d]", i), int'(level), 8 - i);
            frames(1);
            chk($sformatf("exp_post[%0d]", i), int'(level), 7 - i);
            do_sample(-10400);
            chk($sformatf("exp_out[%0d]", i), int'(sample_out), -((10400 * (7 - i)) / 8));
            if (i == 0) begin
                do_sample(-1);
                chk("exp_minus1", int'(sample_out), 0);
            end
            prev = cum[i];
        end
        chk("exp_busy", int'(busy), 0);
        chk("exp_done_cnt", done_cnt - d0, 1);

        // attack then release at level 5
        d0 = done_cnt;
        start(3, 1'b0, 1'b1);
        chk("att_level0", int'(level), 0);
        chk("att_busy", int'(busy), 1);
        do_sample(10400);
        chk("att_out0", int'(sample_out), 0);
        for (int i = 1; i <= 8; i++) begin
            frames(1);
            chk($sformatf("att_level[%0d]", i), int'(level), i);
            do_sample(10400);
            chk($sformatf("att_out[%0d]", i), int'(sample_out), 1300 * i);
        end
        do_sample(-32768);
        chk("att_min", int'(sample_out), -32768);
        frames(2);
        chk("att_dec_hold", int'(level), 8);
        frames(1);
        chk("att_dec7", int'(level), 7);
        frames(6);
        chk("att_dec5", int'(level), 5);
        note_release = 1'b1;
        @(negedge clk);
        note_release = 1'b0;
        chk("rel_level5", int'(level), 5);
        for (int j = 0; j < 5; j++) begin
            frames(1);
            chk($sformatf("rel_level[%0d]", j), int'(level), 4 - j);
        end
        chk("rel_done", int'(env_done), 1);
        chk("rel_busy", int'(busy), 0);
        @(negedge clk);
        chk("rel_done_pulse", int'(env_done), 0);
        chk("rel_done_cnt", done_cnt - d0, 1);
        note_release = 1'b1;
        @(negedge clk);
        note_release = 1'b0;
        chk("rel_idle_busy", int'(busy), 0);

        // restart, coincident new_frame not counted
        start(3, 1'b0, 1'b0);
        frames(15);
        chk("rs_level3", int'(level), 3);
        new_frame = 1'b1;
        start(3, 1'b0, 1'b0);
        new_frame = 1'b0;
        chk("rs_level8", int'(level), 8);
        frames(2);
        chk("rs_cnt_hold", int'(level), 8);
        frames(1);
        chk("rs_cnt_step", int'(level), 7);
        note_release = 1'b1;
        start(3, 1'b0, 1'b0);
        note_release = 1'b0;
        chk("sr_level", int'(level), 8);
        frames(1);
        chk("sr_not_release", int'(level), 8);
        chk("sr_busy", int'(busy), 1);

        // duration 0, then reset mid-decay
        d0 = done_cnt;
        start(0, 1'b0, 1'b0);
        frames(1);
        chk("d0_level7", int'(level), 7);
        frames(3);
        chk("d0_level4", int'(level), 4);
        do_sample(10400);
        chk("d0_out", int'(sample_out), 5200);
        sample_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("ar_level", int'(level), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_out", int'(sample_out), 0);
        chk("ar_valid", int'(sample_out_valid), 0);
        chk("ar_done", int'(env_done), 0);
        @(negedge clk);
        chk("ar_valid_held", int'(sample_out_valid), 0);
        sample_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("ar_done_cnt", done_cnt - d0, 0);

        d0 = done_cnt;
        start(0, 1'b0, 1'b0);
        frames(7);
        chk("d0_level1", int'(level), 1);
        frames(1);
        chk("d0_level0", int'(level), 0);
        chk("d0_done", int'(env_done), 1);
        chk("d0_busy", int'(busy), 0);
        @(negedge clk);
        chk("d0_done_cnt", done_cnt - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
